dcache_tag_ctrl: RTL

//  Sole access controller for the dcache tag array: one single-port RAM per way,

---
 rtl/dcache_tag_ctrl_pkg.sv | 28 ++
 rtl/dcache_tag_sweep.sv | 41 ++++
 rtl/dcache_tag_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dcache_tag_ctrl_pkg.sv
// Shared definitions for the dcache tag-array controller: geometry, entry layout, FSM states.
package dcache_tag_ctrl_pkg;

  localparam int unsigned SETS        = 64;
  localparam int unsigned WAYS        = 8;
  localparam int unsigned IW          = $clog2(SETS);
  localparam int unsigned WW          = $clog2(WAYS);
  localparam int unsigned TAG_W       = 44;
  localparam int unsigned TAG_VLD_BIT = TAG_W - 1;
  localparam int unsigned CNT_W       = IW + WW;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETS * WAYS - 1);

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StFlush
  } tag_state_e;

  // Entry written by the invalidation sweep: valid bit clear, payload zeroed.
  function automatic logic [TAG_W-1:0] invalid_entry();
    logic [TAG_W-1:0] e;
    e              = '0;
    e[TAG_VLD_BIT] = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/dcache_tag_sweep.sv
// Invalidation sweep walker: {index, way} counter, last-entry detect and completion pulse.
module dcache_tag_sweep
  import dcache_tag_ctrl_pkg::*;
(
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_active,
  output logic [IW-1:0] o_index,
  output logic [WW-1:0] o_way,
  output logic          o_last,
  output logic          o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_last;

  assign w_last = (r_cnt == CNT_LAST);

  // Counter parks at the last entry and is cleared once the sweep is no longer active,
  // so every new sweep starts from entry 0.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= i_active && w_last;
      if (!i_active) begin
        r_cnt <= '0;
      end else if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_index = r_cnt[CNT_W-1:WW];
  assign o_way   = r_cnt[WW-1:0];
  assign o_last  = w_last;
  assign o_done  = r_done;

endmodule

// File: rtl/dcache_tag_ctrl.sv
// Tag-array access controller: one grant per cycle among lookup, fill and sweep write,
// with bounded lookup starvation and reset/flush invalidation sweeps.
module dcache_tag_ctrl
  import dcache_tag_ctrl_pkg::*;
#(
  parameter int unsigned FILL_MAX = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_lkp_valid,
  input  logic [IW-1:0]    i_lkp_index,
  output logic             o_lkp_ready,
  input  logic             i_lkp_hold_ready,
  input  logic             i_fill_valid,
  input  logic [IW-1:0]    i_fill_index,
  input  logic [WW-1:0]    i_fill_way,
  input  logic [TAG_W-1:0] i_fill_wdata,
  output logic             o_fill_ready,
  input  logic             i_flush_req,
  output logic             o_busy,
  output logic             o_flush_done,
  output logic             o_lookup2tag_array_valid,
  output logic [IW-1:0]    o_lookup2tag_array_index,
  output logic             o_lookup2tag_array_ready,
  output logic             o_fill2tag_array_valid,
  output logic [IW-1:0]    o_fill2tag_array_index,
  output logic [WW-1:0]    o_fill2tag_array_way,
  output logic [TAG_W-1:0] o_fill2tag_array_wdata
);

  localparam int unsigned SW = $clog2(FILL_MAX + 1);

  tag_state_e    r_state;
  tag_state_e    w_state_d;
  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_d;

  logic          w_sweep;
  logic          w_run;
  logic          w_lkp_grant;
  logic          w_fill_grant;
  logic [IW-1:0] w_sw_index;
  logic [WW-1:0] w_sw_way;
  logic          w_sw_last;
  logic          w_sw_done;

  assign w_sweep = (r_state != StRun);
  assign w_run   = (r_state == StRun) && i_reset;

  dcache_tag_sweep u_sweep (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_active (w_sweep),
    .o_index  (w_sw_index),
    .o_way    (w_sw_way),
    .o_last   (w_sw_last),
    .o_done   (w_sw_done)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state  <= StInit;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_d;
      r_starve <= w_starve_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StInit, StFlush: if (w_sw_last) w_state_d = StRun;
      StRun:           if (i_flush_req) w_state_d = StFlush;
      default:         w_state_d = StInit;
    endcase
  end

  // Fill wins by default; a lookup that has watched FILL_MAX fills go by wins once.
  always_comb begin
    w_lkp_grant  = 1'b0;
    w_fill_grant = 1'b0;
    if (w_run) begin
      w_lkp_grant  = i_lkp_valid && (!i_fill_valid || (r_starve == SW'(FILL_MAX)));
      w_fill_grant = i_fill_valid && !w_lkp_grant;
    end
  end

  always_comb begin
    w_starve_d = r_starve;
    if (!i_lkp_valid || w_lkp_grant) begin
      w_starve_d = '0;
    end else if (w_fill_grant) begin
      w_starve_d = r_starve + SW'(1);
    end
  end

  always_comb begin
    o_lkp_ready              = w_lkp_grant;
    o_fill_ready             = w_fill_grant;
    o_busy                   = w_sweep;
    o_flush_done             = w_sw_done && i_reset;
    o_lookup2tag_array_valid = w_lkp_grant;
    o_lookup2tag_array_index = '0;
    o_lookup2tag_array_ready = i_lkp_hold_ready;
    o_fill2tag_array_valid   = 1'b0;
    o_fill2tag_array_index   = '0;
    o_fill2tag_array_way     = '0;
    o_fill2tag_array_wdata   = '0;
    if (w_lkp_grant) begin
      o_lookup2tag_array_index = i_lkp_index;
    end
    if (w_sweep && i_reset) begin
      o_fill2tag_array_valid = 1'b1;
      o_fill2tag_array_index = w_sw_index;
      o_fill2tag_array_way   = w_sw_way;
      o_fill2tag_array_wdata = invalid_entry();
    end else if (w_fill_grant) begin
      o_fill2tag_array_valid = 1'b1;
      o_fill2tag_array_index = i_fill_index;
      o_fill2tag_array_way   = i_fill_way;
      o_fill2tag_array_wdata = i_fill_wdata;
    end
  end

endmodule
